apb_reg_completer: RTL and testbench

- APB completer (responder) at the far end of an apbDecode output port, e.g. a per-block apb_uBlockX link; the cpu is the initiator and apbDecode the router.
- Decodes word addresses into a small bank of control registers and drives the read and error response.
- Inserts a configurable number of wait states and exposes register contents and per-register write strobes to the host block.

---
 rtl/apb_reg_completer_pkg.sv | 17 +
 rtl/apb_reg_completer_decode.sv | 29 ++
 rtl/apb_reg_completer.sv | 193 +++++++++++++++++++
 tb/tb_apb_reg_completer.sv | 320 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/apb_reg_completer_pkg.sv
// Shared types and constants for the APB register completer and its address decoder.
package apb_reg_completer_package;

    typedef enum logic {
        IDLE   = 1'b0,
        ACCESS = 1'b1
    } state_e;

    localparam logic [31:0] ID_VALUE_DEFAULT = 32'hA2C0_0001;
    localparam int          REG_IDX_LSB      = 2;
    localparam int          WAIT_CNT_W       = 4;

    // Index type is wide enough for up to 256 registers; narrower banks zero-extend.
    localparam int REG_IDX_W = 8;
    typedef logic [REG_IDX_W-1:0] reg_idx_t;

endpackage

// File: rtl/apb_reg_completer_decode.sv
// Combinational word-address decode: paddr/pwrite -> register index and error flag.
module apb_reg_completer_decode
    import apb_reg_completer_package::*;
#(
    parameter int ADDR_W   = 32,
    parameter int NUM_REGS = 8
) (
    input  logic [ADDR_W-1:0] paddr_i,
    input  logic              pwrite_i,
    output reg_idx_t          idx_o,
    output logic              err_o
);

    localparam int IDX_W  = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
    localparam int HI_LSB = REG_IDX_LSB + IDX_W;

    logic [IDX_W-1:0] field;
    logic             hi_nz;

    // Error on misalignment, bits above the index field, holes past NUM_REGS, or writes to the ID register.
    always_comb begin
        field = paddr_i[REG_IDX_LSB +: IDX_W];
        hi_nz = (paddr_i >> HI_LSB) != '0;
        idx_o = reg_idx_t'(field);
        err_o = (paddr_i[1:0] != 2'b00) || hi_nz ||
                (idx_o >= reg_idx_t'(NUM_REGS)) || (pwrite_i && (idx_o == '0));
    end

endmodule

// File: rtl/apb_reg_completer.sv
// APB completer with a small control-register bank and configurable wait states.
// Optional byte-lane writes via pstrb when APB_REG_COMPLETER_PSTRB_EN is defined.
module apb_reg_completer
    import apb_reg_completer_package::*;
#(
    parameter int                ADDR_W      = 32,
    parameter int                DATA_W      = 32,
    parameter int                NUM_REGS    = 8,
    parameter int                WAIT_STATES = 0,
    parameter logic [DATA_W-1:0] ID_VALUE    = ID_VALUE_DEFAULT
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       psel,
    input  logic                       penable,
    input  logic                       pwrite,
    input  logic [ADDR_W-1:0]          paddr,
    input  logic [DATA_W-1:0]          pwdata,
`ifdef APB_REG_COMPLETER_PSTRB_EN
    input  logic [DATA_W/8-1:0]        pstrb,
`endif
    output logic [DATA_W-1:0]          prdata,
    output logic                       pready,
    output logic                       pslverr,
    output logic [NUM_REGS*DATA_W-1:0] reg_q,
    output logic [NUM_REGS-1:0]        wr_pulse
);

    localparam int STRB_W = DATA_W / 8;

    // Handshake: a transfer completes in the cycle where psel, penable and pready are all
    // high; prdata and pslverr are meaningful only in that cycle and read as 0 otherwise.

    state_e                  state_q, state_d;
    logic [WAIT_CNT_W-1:0]   cnt_q, cnt_d;
    logic                    pready_q, pready_d;
    logic                    pslverr_q, pslverr_d;
    logic [DATA_W-1:0]       prdata_q, prdata_d;
    logic [NUM_REGS-1:0]     wr_pulse_q, wr_pulse_d;
    reg_idx_t                idx_q, idx_d;
    logic                    write_q, write_d;
    logic                    err_q, err_d;
    logic [DATA_W-1:0]       wdata_q, wdata_d;
    logic [STRB_W-1:0]       strb_q, strb_d;
    logic [DATA_W-1:0]       regs_q [1:NUM_REGS-1];
    logic [DATA_W-1:0]       regs_d [1:NUM_REGS-1];

    reg_idx_t                dec_idx;
    logic                    dec_err;
    logic [STRB_W-1:0]       strb_in;
    reg_idx_t                rd_idx;
    logic [DATA_W-1:0]       rd_word;
    logic                    cur_err, cur_wr, respond;
    logic [DATA_W-1:0]       wmask;

`ifdef APB_REG_COMPLETER_PSTRB_EN
    assign strb_in = pstrb;
`else
    assign strb_in = '1;
`endif

    apb_reg_completer_decode #(
        .ADDR_W   (ADDR_W),
        .NUM_REGS (NUM_REGS)
    ) u_decode (
        .paddr_i  (paddr),
        .pwrite_i (pwrite),
        .idx_o    (dec_idx),
        .err_o    (dec_err)
    );

    // With zero wait states the response is produced on the setup edge from the live decode.
    always_comb begin
        rd_idx  = (state_q == IDLE) ? dec_idx : idx_q;
        cur_err = (state_q == IDLE) ? dec_err : err_q;
        cur_wr  = (state_q == IDLE) ? pwrite  : write_q;
        rd_word = ID_VALUE;
        for (int i = 1; i < NUM_REGS; i++) begin
            if (rd_idx == reg_idx_t'(i)) rd_word = regs_q[i];
        end
        for (int b = 0; b < STRB_W; b++) begin
            wmask[b*8 +: 8] = {8{strb_q[b]}};
        end
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        pready_d   = pready_q;
        pslverr_d  = pslverr_q;
        prdata_d   = prdata_q;
        wr_pulse_d = '0;
        idx_d      = idx_q;
        write_d    = write_q;
        err_d      = err_q;
        wdata_d    = wdata_q;
        strb_d     = strb_q;
        regs_d     = regs_q;
        respond    = 1'b0;

        case (state_q)
            IDLE: begin
                if (psel && !penable) begin
                    state_d = ACCESS;
                    idx_d   = dec_idx;
                    write_d = pwrite;
                    err_d   = dec_err;
                    wdata_d = pwdata;
                    strb_d  = strb_in;
                    cnt_d   = WAIT_CNT_W'(WAIT_STATES);
                    respond = (WAIT_STATES == 0);
                end
            end
            ACCESS: begin
                if (!pready_q) begin
                    if (!psel) begin
                        state_d = IDLE;
                        cnt_d   = '0;
                    end else if (cnt_q <= WAIT_CNT_W'(1)) begin
                        cnt_d   = '0;
                        respond = 1'b1;
                    end else begin
                        cnt_d = cnt_q - WAIT_CNT_W'(1);
                    end
                end else begin
                    state_d   = IDLE;
                    pready_d  = 1'b0;
                    pslverr_d = 1'b0;
                    prdata_d  = '0;
                    if (psel && penable && write_q && !err_q && (strb_q != '0)) begin
                        for (int i = 1; i < NUM_REGS; i++) begin
                            if (idx_q == reg_idx_t'(i)) begin
                                regs_d[i]     = (regs_q[i] & ~wmask) | (wdata_q & wmask);
                                wr_pulse_d[i] = 1'b1;
                            end
                        end
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        if (respond) begin
            pready_d  = 1'b1;
            pslverr_d = cur_err;
            prdata_d  = (cur_err || cur_wr) ? '0 : rd_word;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            pready_q   <= 1'b0;
            pslverr_q  <= 1'b0;
            prdata_q   <= '0;
            wr_pulse_q <= '0;
            idx_q      <= '0;
            write_q    <= 1'b0;
            err_q      <= 1'b0;
            wdata_q    <= '0;
            strb_q     <= '0;
            for (int i = 1; i < NUM_REGS; i++) regs_q[i] <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            pready_q   <= pready_d;
            pslverr_q  <= pslverr_d;
            prdata_q   <= prdata_d;
            wr_pulse_q <= wr_pulse_d;
            idx_q      <= idx_d;
            write_q    <= write_d;
            err_q      <= err_d;
            wdata_q    <= wdata_d;
            strb_q     <= strb_d;
            for (int i = 1; i < NUM_REGS; i++) regs_q[i] <= regs_d[i];
        end
    end

    assign prdata   = prdata_q;
    assign pready   = pready_q;
    assign pslverr  = pslverr_q;
    assign wr_pulse = wr_pulse_q;

    for (genvar g = 0; g < NUM_REGS; g++) begin : g_flat
        if (g == 0) begin : g_id
            assign reg_q[g*DATA_W +: DATA_W] = ID_VALUE;
        end else begin : g_rw
            assign reg_q[g*DATA_W +: DATA_W] = regs_q[g];
        end
    end

endmodule

// File: tb/tb_apb_reg_completer.sv
// Self-checking bench: two completers (0 and 3 wait states) share one APB master, selected by tgt.
module tb_apb_reg_completer;

    localparam int          NR  = 8;
    localparam int          WS3 = 3;
    localparam logic [31:0] ID  = 32'hA2C0_0001;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        psel, penable, pwrite, tgt;
    logic [31:0] paddr, pwdata;
    logic [3:0]  pstrb;

    logic         psel0, psel3;
    logic [31:0]  prdata0, prdata3, prdata;
    logic         pready0, pready3, pready, pslverr0, pslverr3, pslverr;
    logic [255:0] reg_q0, reg_q3, reg_q;
    logic [7:0]   wr_pulse0, wr_pulse3, wr_pulse;

    logic [31:0]  exp_regs [2][NR];
    logic [33:0]  exp_q [$];
    int           n_tests = 0;
    int           n_fails = 0;

    assign psel0    = psel & ~tgt;
    assign psel3    = psel & tgt;
    assign prdata   = tgt ? prdata3   : prdata0;
    assign pready   = tgt ? pready3   : pready0;
    assign pslverr  = tgt ? pslverr3  : pslverr0;
    assign reg_q    = tgt ? reg_q3    : reg_q0;
    assign wr_pulse = tgt ? wr_pulse3 : wr_pulse0;

    apb_reg_completer #(.WAIT_STATES(0)) dut0 (
        .clk(clk), .rst_n(rst_n), .psel(psel0), .penable(penable), .pwrite(pwrite),
        .paddr(paddr), .pwdata(pwdata),
`ifdef APB_REG_COMPLETER_PSTRB_EN
        .pstrb(pstrb),
`endif
        .prdata(prdata0), .pready(pready0), .pslverr(pslverr0),
        .reg_q(reg_q0), .wr_pulse(wr_pulse0)
    );

    apb_reg_completer #(.WAIT_STATES(WS3)) dut3 (
        .clk(clk), .rst_n(rst_n), .psel(psel3), .penable(penable), .pwrite(pwrite),
        .paddr(paddr), .pwdata(pwdata),
`ifdef APB_REG_COMPLETER_PSTRB_EN
        .pstrb(pstrb),
`endif
        .prdata(prdata3), .pready(pready3), .pslverr(pslverr3),
        .reg_q(reg_q3), .wr_pulse(wr_pulse3)
    );

    // clock / reset
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic exp_err(input logic wr, input logic [31:0] a);
        return (a[1:0] != 2'b00) || (a > 32'h1C) || (wr && (a[4:2] == 3'd0));
    endfunction

    function automatic logic [255:0] exp_pack(input logic t);
        logic [255:0] v;
        for (int i = 0; i < NR; i++) v[i*32 +: 32] = exp_regs[t][i];
        return v;
    endfunction

    task automatic model_reset();
        for (int t = 0; t < 2; t++)
            for (int i = 0; i < NR; i++) exp_regs[t][i] = (i == 0) ? ID : 32'h0;
        exp_q.delete();
    endtask

    // One full transfer on the selected completer; call away from a rising edge.
    task automatic xfer(input logic wr, input logic [31:0] a, input logic [31:0] d,
                        input logic [3:0] s);
        int          ws, cyc;
        bit          done;
        logic        err;
        logic [33:0] e;
        logic [31:0] mask;
        logic [7:0]  exp_pulse;
        ws        = tgt ? WS3 : 0;
        err       = exp_err(wr, a);
        exp_pulse = '0;
        e = {(!wr || err), err, ((err || wr) ? 32'h0 : exp_regs[tgt][a[4:2]])};
        exp_q.push_back(e);
        if (wr && !err && (s != 4'h0)) begin
            for (int b = 0; b < 4; b++) mask[b*8 +: 8] = {8{s[b]}};
            exp_regs[tgt][a[4:2]] = (exp_regs[tgt][a[4:2]] & ~mask) | (d & mask);
            exp_pulse[a[4:2]] = 1'b1;
        end
        psel = 1'b1; penable = 1'b0; pwrite = wr; paddr = a; pwdata = d; pstrb = s;
        @(posedge clk); #1 penable = 1'b1;
        cyc = 0; done = 0;
        while (!done && cyc < 40) begin
            @(negedge clk);
            cyc++;
            if (pready === 1'b1) begin
                done = 1;
                e = exp_q.pop_front();
                n_tests++;
                if (cyc != ws + 1) begin
                    n_fails++;
                    $display("FAIL latency addr=%h: pready in access cycle %0d, expected %0d", a, cyc, ws + 1);
                end
                n_tests++;
                if (pslverr !== e[32]) begin
                    n_fails++;
                    $display("FAIL pslverr addr=%h wr=%0b: got %b expected %b", a, wr, pslverr, e[32]);
                end
                if (e[33]) begin
                    n_tests++;
                    if (prdata !== e[31:0]) begin
                        n_fails++;
                        $display("FAIL prdata addr=%h: got %h expected %h", a, prdata, e[31:0]);
                    end
                end
            end
        end
        if (!done) begin
            n_tests++; n_fails++;
            $display("FAIL timeout addr=%h: no pready within 40 cycles", a);
            exp_q.delete();
        end
        @(posedge clk); #1 psel = 1'b0; penable = 1'b0;
        n_tests++;
        if (pready !== 1'b0) begin
            n_fails++;
            $display("FAIL pready_width addr=%h: pready %b after completion, expected 0", a, pready);
        end
        n_tests++;
        if (wr_pulse !== exp_pulse) begin
            n_fails++;
            $display("FAIL wr_pulse addr=%h: got %b expected %b", a, wr_pulse, exp_pulse);
        end
        n_tests++;
        if (reg_q !== exp_pack(tgt)) begin
            n_fails++;
            $display("FAIL reg_q after addr=%h: got %h expected %h", a, reg_q, exp_pack(tgt));
        end
    endtask

    task automatic check_outputs_idle(input string name);
        n_tests++;
        if ({pready0, pslverr0, prdata0, wr_pulse0, pready3, pslverr3, prdata3, wr_pulse3} !== '0) begin
            n_fails++;
            $display("FAIL %s outputs: p0=%b e0=%b d0=%h w0=%b p3=%b e3=%b d3=%h w3=%b expected all 0",
                     name, pready0, pslverr0, prdata0, wr_pulse0, pready3, pslverr3, prdata3, wr_pulse3);
        end
        n_tests++;
        if (reg_q0 !== exp_pack(1'b0) || reg_q3 !== exp_pack(1'b1)) begin
            n_fails++;
            $display("FAIL %s regs: r0=%h r3=%h expected %h", name, reg_q0, reg_q3, exp_pack(1'b0));
        end
    endtask

    task automatic test_reset();
        psel = 0; penable = 0; pwrite = 0; paddr = 0; pwdata = 0; pstrb = 4'hF; tgt = 0;
        rst_n = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1 check_outputs_idle("reset");
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_id_read();
        tgt = 0;
        xfer(1'b0, 32'h00, 32'h0, 4'hF);
    endtask

    task automatic test_write_read();
        tgt = 0;
        xfer(1'b1, 32'h08, 32'hDEAD_BEEF, 4'hF);
        n_tests++;
        if (reg_q[95:64] !== 32'hDEAD_BEEF) begin
            n_fails++;
            $display("FAIL reg2_slice: got %h expected deadbeef", reg_q[95:64]);
        end
        @(posedge clk); #1;
        n_tests++;
        if (wr_pulse !== 8'h00) begin
            n_fails++;
            $display("FAIL wr_pulse_width: got %b one cycle later, expected 0", wr_pulse);
        end
        xfer(1'b0, 32'h08, 32'h0, 4'hF);
    endtask

    task automatic test_wait_states();
        tgt = 1;
        xfer(1'b0, 32'h04, 32'h0, 4'hF);
        xfer(1'b1, 32'h04, 32'h1234_5678, 4'hF);
        xfer(1'b0, 32'h04, 32'h0, 4'hF);
        xfer(1'b0, 32'h00, 32'h0, 4'hF);
    endtask

    task automatic test_errors();
        tgt = 0;
        xfer(1'b1, 32'h00, 32'h5555_5555, 4'hF);
        xfer(1'b0, 32'h20, 32'h0, 4'hF);
        xfer(1'b1, 32'h06, 32'h6666_6666, 4'hF);
        xfer(1'b0, 32'h0000_1004, 32'h0, 4'hF);
        tgt = 1;
        xfer(1'b1, 32'h1F, 32'h7777_7777, 4'hF);
    endtask

    task automatic test_back_to_back();
        for (int t = 0; t < 2; t++) begin
            tgt = t[0];
            xfer(1'b1, 32'h10, 32'hC0DE_0000 + t, 4'hF);
            xfer(1'b0, 32'h10, 32'h0, 4'hF);
            xfer(1'b1, 32'h1C, 32'h0BAD_F00D, 4'hF);
            xfer(1'b0, 32'h1C, 32'h0, 4'hF);
        end
    endtask

    task automatic test_abort();
        bit seen;
        tgt = 1;
        psel = 1; penable = 0; pwrite = 1; paddr = 32'h0C; pwdata = 32'hFEED_FACE; pstrb = 4'hF;
        @(posedge clk); #1 penable = 1'b1;
        @(posedge clk); #1 psel = 1'b0; penable = 1'b0;
        seen = 0;
        repeat (8) begin
            @(negedge clk);
            if (pready !== 1'b0 || wr_pulse !== 8'h00) seen = 1;
        end
        n_tests++;
        if (seen) begin
            n_fails++;
            $display("FAIL abort_response: pready/wr_pulse asserted after aborted transfer");
        end
        n_tests++;
        if (reg_q !== exp_pack(tgt)) begin
            n_fails++;
            $display("FAIL abort_regs: got %h expected %h", reg_q, exp_pack(tgt));
        end
        @(posedge clk); #1;
        xfer(1'b0, 32'h0C, 32'h0, 4'hF);
        xfer(1'b1, 32'h0C, 32'hA5A5_5A5A, 4'hF);
        xfer(1'b0, 32'h0C, 32'h0, 4'hF);
    endtask

    task automatic test_reset_mid();
        tgt = 1;
        psel = 1; penable = 0; pwrite = 1; paddr = 32'h14; pwdata = 32'h1357_9BDF; pstrb = 4'hF;
        @(posedge clk); #1 penable = 1'b1;
        @(posedge clk);
        @(negedge clk) rst_n = 1'b0;
        model_reset();
        #1 check_outputs_idle("reset_mid_write");
        psel = 0; penable = 0;
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;
        tgt = 0;
        psel = 1; penable = 0; pwrite = 0; paddr = 32'h00;
        @(posedge clk); #1 penable = 1'b1;
        @(negedge clk);
        n_tests++;
        if (pready0 !== 1'b1 || prdata0 !== ID) begin
            n_fails++;
            $display("FAIL reset_mid_pre: pready=%b prdata=%h expected 1 / %h", pready0, prdata0, ID);
        end
        #1 rst_n = 1'b0;
        #1 check_outputs_idle("reset_mid_read");
        psel = 0; penable = 0;
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_random();
        logic        wr;
        logic [31:0] a;
        for (int n = 0; n < 24; n++) begin
            tgt = 1'($urandom_range(0, 1));
            wr  = 1'($urandom_range(0, 1));
            a   = {27'd0, 3'($urandom_range(0, 7)), 2'b00};
            if ($urandom_range(0, 7) == 0) a = a | 32'($urandom_range(1, 3));
            xfer(wr, a, $urandom, 4'hF);
        end
    endtask

`ifdef APB_REG_COMPLETER_PSTRB_EN
    task automatic test_pstrb();
        tgt = 0;
        xfer(1'b1, 32'h04, 32'h1122_3344, 4'hF);
        xfer(1'b1, 32'h04, 32'hAABB_CCDD, 4'b0101);
        n_tests++;
        if (reg_q[63:32] !== 32'h11BB_33DD) begin
            n_fails++;
            $display("FAIL pstrb_merge: got %h expected 11bb33dd", reg_q[63:32]);
        end
        xfer(1'b1, 32'h04, 32'hFFFF_FFFF, 4'b0000);
        xfer(1'b0, 32'h04, 32'h0, 4'hF);
    endtask
`endif

    initial begin
        test_reset();
        test_id_read();
        test_write_read();
        test_wait_states();
        test_errors();
        test_back_to_back();
        test_abort();
        test_reset_mid();
`ifdef APB_REG_COMPLETER_PSTRB_EN
        test_pstrb();
`endif
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fails);
        $finish;
    end

endmodule
